// File: rtl/adc_display_driver.sv
// rtl/adc_display_driver.sv - 4-digit multiplexed 7-segment driver for the 16-bit ADC result
// Optional feature macro: DECIMAL_POINT_EN (decimal point on digit DP_POS in BCD mode).
module adc_display_driver #(
  parameter int REFRESH_DIV  = 100_000,
  parameter int UPDATE_DIV   = 25_000_000,
  parameter int BLANK_CYCLES = 16,
  parameter int DP_POS       = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        bcd_mode,
  input  logic        freeze,
  output logic [3:0]  anode,
  output logic [6:0]  cathode,
  output logic        dp
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int UW = $clog2(UPDATE_DIV);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [UW-1:0] UPDATE_LAST  = UW'(UPDATE_DIV - 1);
  localparam logic [RW-1:0] BLANK_LIM    = RW'(BLANK_CYCLES);

  logic [RW-1:0] r_refresh_cnt;
  logic [UW-1:0] r_update_cnt;
  logic [1:0]    r_digit_sel;
  logic [15:0]   r_shown_value;
  logic [3:0]    r_anode;
  logic [6:0]    r_cathode;
  logic          r_dp;

  logic          w_refresh_wrap;
  logic          w_update_wrap;
  logic [3:0]    w_nib;
  logic          w_upper_zero;
  logic          w_lz_blank;
  logic          w_blank;
  logic [6:0]    w_glyph;
  logic [3:0]    w_anode;
  logic [6:0]    w_cathode;
  logic          w_dp;

  assign w_refresh_wrap = (r_refresh_cnt == REFRESH_LAST);
  assign w_update_wrap  = (r_update_cnt == UPDATE_LAST);
  assign w_nib          = r_shown_value[{r_digit_sel, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_refresh_cnt <= '0;
      r_update_cnt  <= '0;
      r_digit_sel   <= 2'd0;
      r_shown_value <= 16'h0000;
    end else begin
      r_refresh_cnt <= w_refresh_wrap ? '0 : r_refresh_cnt + 1'b1;
      r_update_cnt  <= w_update_wrap ? '0 : r_update_cnt + 1'b1;
      if (w_refresh_wrap) begin
        r_digit_sel <= r_digit_sel + 2'd1;
      end
      if (w_update_wrap && !freeze) begin
        r_shown_value <= value;
      end
    end
  end

  // A dash nibble (>9) is non-zero, so it naturally stops leading-zero blanking.
  always_comb begin
    w_upper_zero = 1'b0;
    case (r_digit_sel)
      2'd1:    w_upper_zero = (r_shown_value[15:4] == 12'd0);
      2'd2:    w_upper_zero = (r_shown_value[15:8] == 8'd0);
      2'd3:    w_upper_zero = (r_shown_value[15:12] == 4'd0);
      default: w_upper_zero = 1'b0;
    endcase
  end

`ifdef DECIMAL_POINT_EN
  assign w_lz_blank = bcd_mode && w_upper_zero && (r_digit_sel > 2'(DP_POS));
`else
  assign w_lz_blank = bcd_mode && (r_digit_sel != 2'd0) && w_upper_zero;
`endif

  assign w_blank = (r_refresh_cnt < BLANK_LIM) || w_lz_blank;

  always_comb begin
    w_glyph = 7'h7F;
    case (w_nib)
      4'h0: w_glyph = 7'b1000000;
      4'h1: w_glyph = 7'b1111001;
      4'h2: w_glyph = 7'b0100100;
      4'h3: w_glyph = 7'b0110000;
      4'h4: w_glyph = 7'b0011001;
      4'h5: w_glyph = 7'b0010010;
      4'h6: w_glyph = 7'b0000010;
      4'h7: w_glyph = 7'b1111000;
      4'h8: w_glyph = 7'b0000000;
      4'h9: w_glyph = 7'b0010000;
      4'hA: w_glyph = 7'b0001000;
      4'hB: w_glyph = 7'b0000011;
      4'hC: w_glyph = 7'b1000110;
      4'hD: w_glyph = 7'b0100001;
      4'hE: w_glyph = 7'b0000110;
      4'hF: w_glyph = 7'b0001110;
      default: w_glyph = 7'h7F;
    endcase
    if (bcd_mode && (w_nib > 4'd9)) begin
      w_glyph = 7'b0111111;
    end
  end

  always_comb begin
    w_anode   = 4'b1111;
    w_cathode = 7'h7F;
    w_dp      = 1'b1;
    if (!w_blank) begin
      w_anode   = ~(4'b0001 << r_digit_sel);
      w_cathode = w_glyph;
`ifdef DECIMAL_POINT_EN
      w_dp      = !(bcd_mode && (r_digit_sel == 2'(DP_POS)));
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_anode   <= 4'b1111;
      r_cathode <= 7'h7F;
      r_dp      <= 1'b1;
    end else begin
      r_anode   <= w_anode;
      r_cathode <= w_cathode;
      r_dp      <= w_dp;
    end
  end

  assign anode   = r_anode;
  assign cathode = r_cathode;
  assign dp      = r_dp;

endmodule

// File: tb/tb_adc_display_driver.sv
// tb/tb_adc_display_driver.sv - self-checking bench for adc_display_driver
// Default build only (DECIMAL_POINT_EN undefined): dp expected high throughout.
module tb_adc_display_driver;

  localparam int RDIV = 8;
  localparam int UDIV = 64;
  localparam int BLK  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'h0000;
  logic        bcd_mode = 1'b1;
  logic        freeze = 1'b0;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        dp;

  adc_display_driver #(
    .REFRESH_DIV (RDIV),
    .UPDATE_DIV  (UDIV),
    .BLANK_CYCLES(BLK),
    .DP_POS      (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .value   (value),
    .bcd_mode(bcd_mode),
    .freeze  (freeze),
    .anode   (anode),
    .cathode (cathode),
    .dp      (dp)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [3:0] AN_FOR [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [11:0] BLANK_OUT = 12'hFFF;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: cycles since reset release and the value currently on show.
  int          m_n = 0;
  int          last_k = 0;
  logic [15:0] m_shown = 16'h0000;
  logic        m_wrapped = 1'b0;
  logic [11:0] m_exp = 12'hFFF;

  typedef struct {
    logic        bcd;
    logic [15:0] val;
    int          d;
    logic [3:0]  an;
    logic [6:0]  cat;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [11:0] model_out(input int k, input logic [15:0] sh, input logic bcd);
    int          slot;
    int          d;
    logic [3:0]  nib;
    logic [6:0]  cat;
    slot = k % RDIV;
    d    = (k / RDIV) % 4;
    nib  = sh[4*d +: 4];
    if (slot < BLK) return BLANK_OUT;
    if (bcd && d != 0 && (sh >> (4 * d)) == 16'h0000) return BLANK_OUT;
    cat = (bcd && nib > 4'd9) ? 7'b0111111 : GLYPH[nib];
    return {AN_FOR[d], cat, 1'b1};
  endfunction

  task automatic step();
    @(posedge clk);
    m_wrapped = 1'b0;
    if (reset) begin
      m_exp   = BLANK_OUT;
      m_n     = 0;
      m_shown = 16'h0000;
    end else begin
      last_k = m_n;
      m_exp  = model_out(m_n, m_shown, bcd_mode);
      if (m_n % UDIV == UDIV - 1) begin
        m_wrapped = 1'b1;
        if (!freeze) m_shown = value;
      end
      m_n++;
    end
    @(negedge clk);
    chk("cycle_model", 32'({anode, cathode, dp}), 32'(m_exp));
    chk("one_anode", 32'(anode == 4'b1111 || anode == 4'b1110 || anode == 4'b1101 ||
                         anode == 4'b1011 || anode == 4'b0111), 32'd1);
  endtask

  task automatic run_to(input int d, input int pos);
    int guard;
    guard = 0;
    do begin
      step();
      guard++;
    end while (!((last_k % RDIV) == pos && ((last_k / RDIV) % 4) == d) && guard < 100);
    if (guard >= 100) begin
      n_checks++;
      $display("FAIL run_to_timeout actual=%0d required=<100", guard);
    end
  endtask

  task automatic wait_wrap();
    int guard;
    guard = 0;
    do begin
      step();
      guard++;
    end while (!m_wrapped && guard < 200);
    if (guard >= 200) begin
      n_checks++;
      $display("FAIL wrap_timeout actual=%0d required=<200", guard);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 16'h1234, 0, 4'b1110, 7'b0011001};
    vecs[1]  = '{1'b0, 16'h1234, 1, 4'b1101, 7'b0110000};
    vecs[2]  = '{1'b0, 16'h1234, 2, 4'b1011, 7'b0100100};
    vecs[3]  = '{1'b0, 16'h1234, 3, 4'b0111, 7'b1111001};
    vecs[4]  = '{1'b1, 16'h0042, 0, 4'b1110, 7'b0100100};
    vecs[5]  = '{1'b1, 16'h0042, 1, 4'b1101, 7'b0011001};
    vecs[6]  = '{1'b1, 16'h0042, 2, 4'b1111, 7'h7F};
    vecs[7]  = '{1'b1, 16'h0042, 3, 4'b1111, 7'h7F};
    vecs[8]  = '{1'b1, 16'h0000, 0, 4'b1110, 7'b1000000};
    vecs[9]  = '{1'b1, 16'h0000, 1, 4'b1111, 7'h7F};
    vecs[10] = '{1'b1, 16'h0A05, 2, 4'b1011, 7'b0111111};
    vecs[11] = '{1'b1, 16'h0A05, 1, 4'b1101, 7'b1000000};
    vecs[12] = '{1'b1, 16'h0A05, 3, 4'b1111, 7'h7F};
    vecs[13] = '{1'b1, 16'h0A05, 0, 4'b1110, 7'b0010010};
    vecs[14] = '{1'b0, 16'h0000, 3, 4'b0111, 7'b1000000};
    vecs[15] = '{1'b0, 16'hABCD, 3, 4'b0111, 7'b0001000};
    vecs[16] = '{1'b1, 16'h9999, 3, 4'b0111, 7'b0010000};

    // Reset for three cycles, then the first lit slot is digit 0 showing "0".
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("reset_out", 32'({anode, cathode, dp}), 32'(BLANK_OUT));
    reset = 1'b0;
    step();
    chk("post_reset_k0_blank", 32'(anode), 32'(4'b1111));
    step();
    chk("post_reset_k1_blank", 32'(anode), 32'(4'b1111));
    step();
    chk("post_reset_d0_an", 32'(anode), 32'(4'b1110));
    chk("post_reset_d0_cat", 32'(cathode), 32'(7'b1000000));

    // Table-driven frames: latch the value, then look mid-slot at the chosen digit.
    freeze = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bcd_mode = vecs[i].bcd;
      value    = vecs[i].val;
      wait_wrap();
      run_to(vecs[i].d, 4);
      chk($sformatf("vec%0d_anode", i), 32'(anode), 32'(vecs[i].an));
      chk($sformatf("vec%0d_cathode", i), 32'(cathode), 32'(vecs[i].cat));
      chk($sformatf("vec%0d_dp", i), 32'(dp), 32'd1);
    end

    // Anti-ghost interval at the start of a slot.
    bcd_mode = 1'b0;
    value    = 16'h1234;
    wait_wrap();
    run_to(2, 0);
    chk("ghost_pos0", 32'(anode), 32'(4'b1111));
    step();
    chk("ghost_pos1", 32'(anode), 32'(4'b1111));
    step();
    chk("ghost_pos2_lit", 32'(anode), 32'(4'b1011));

    // Freeze across a wrap holds the display; release shows new value only after the next wrap.
    value = 16'h1111;
    wait_wrap();
    freeze = 1'b1;
    value  = 16'h2222;
    wait_wrap();
    run_to(0, 4);
    chk("freeze_hold", 32'(cathode), 32'(7'b1111001));
    freeze = 1'b0;
    run_to(1, 4);
    chk("unfreeze_before_wrap", 32'(cathode), 32'(7'b1111001));
    wait_wrap();
    run_to(0, 4);
    chk("unfreeze_after_wrap", 32'(cathode), 32'(7'b0100100));

    // Reset mid-slot on digit 2.
    bcd_mode = 1'b1;
    value    = 16'h1234;
    wait_wrap();
    run_to(2, 4);
    chk("mid_d2_lit", 32'(anode), 32'(4'b1011));
    reset = 1'b1;
    step();
    chk("mid_reset_out", 32'({anode, cathode, dp}), 32'(BLANK_OUT));
    reset = 1'b0;
    run_to(0, 3);
    chk("mid_restart_d0", 32'({anode, cathode}), 32'({4'b1110, 7'b1000000}));
    run_to(1, 4);
    chk("mid_restart_shown0", 32'(anode), 32'(4'b1111));

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) value = 16'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 63) == 0) bcd_mode = ~bcd_mode;
      if ($urandom_range(0, 127) == 0) freeze = ~freeze;
      reset = ($urandom_range(0, 599) == 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
